// File: rtl/wb_slave_ram.sv
// ---------------------------------------------------------------------------
// wb_slave_ram
//   Wishbone B3 classic-cycle slave backed by a word-organised RAM.
//   Each request is captured and held for WAIT_CYCLES extra cycles. It is
//   then answered with a single-cycle wb_ack_o pulse, or with a wb_err_o
//   pulse when the error option is built in. Writes honour the byte lanes
//   selected by wb_sel_i. Reads always return all four lanes.
//
// Optional feature macro: WB_RAM_ERR_EN
//   defined   : a request outside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_W) ends
//               with wb_err_o. It performs no write and returns no data.
//   undefined : wb_err_o stays 0. The address wraps modulo the window size.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   wb_adr_i  in   [31:0] byte address (bits [1:0] ignored)
//   wb_dat_i  in   [31:0] write data
//   wb_dat_o  out  [31:0] read data, valid only while wb_ack_o = 1
//   wb_we_i   in   1 = write, 0 = read
//   wb_sel_i  in   [3:0] byte-lane enables
//   wb_stb_i  in   strobe
//   wb_cyc_i  in   bus cycle valid
//   wb_ack_o  out  normal termination pulse
//   wb_err_o  out  error termination pulse
// ---------------------------------------------------------------------------
module wb_slave_ram #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_W;

  logic [1:0]        state, state_nxt;
  logic [3:0]        wait_cnt, cnt_nxt;
  logic              go_resp;

  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_dat;
  logic [3:0]        lat_sel;
  logic              lat_we;
  logic              lat_err;

  logic [31:0]       mem [DEPTH];

  logic              req_valid;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] req_idx;
  logic              req_err;
  logic              unused_offset_bits;

  assign req_valid = wb_cyc_i & wb_stb_i;
  assign offset    = wb_adr_i - BASE_ADDR;
  assign req_idx   = offset[ADDR_W+1:2];

  // Byte offset bits and bits above the window are not part of the word index.
  assign unused_offset_bits = ^{offset[1:0], offset[31:ADDR_W+2]};

`ifdef WB_RAM_ERR_EN
  // Below the base the subtraction wraps. Compare the base explicitly as well,
  // so the check still holds for very large windows.
  assign req_err = (wb_adr_i < BASE_ADDR) ||
                   ({1'b0, offset} >= (33'd1 << (ADDR_W + 2)));
`else
  assign req_err = 1'b0;
`endif

  // With zero wait states the response edge is the capture edge itself.
  // The live bus values are used while in IDLE, and the latched copy afterwards.
  logic [ADDR_W-1:0] cur_idx;
  logic [31:0]       cur_dat;
  logic [3:0]        cur_sel;
  logic              cur_we;
  logic              cur_err;

  assign cur_idx = (state == S_IDLE) ? req_idx  : lat_idx;
  assign cur_dat = (state == S_IDLE) ? wb_dat_i : lat_dat;
  assign cur_sel = (state == S_IDLE) ? wb_sel_i : lat_sel;
  assign cur_we  = (state == S_IDLE) ? wb_we_i  : lat_we;
  assign cur_err = (state == S_IDLE) ? req_err  : lat_err;

  // Next-state logic. go_resp marks the edge that enters RESP. The RAM write,
  // the read-data capture and the ack/err pulse all happen on that edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    go_resp   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_nxt = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Dropping the cycle wins over reaching the end of the wait.
        if (!wb_cyc_i) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (wait_cnt == 4'd1) begin
          state_nxt = S_RESP;
          go_resp   = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = wait_cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control, request latches and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      lat_idx  <= '0;
      lat_dat  <= 32'd0;
      lat_sel  <= 4'd0;
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (state == S_IDLE && req_valid) begin
        lat_idx <= req_idx;
        lat_dat <= wb_dat_i;
        lat_sel <= wb_sel_i;
        lat_we  <= wb_we_i;
        lat_err <= req_err;
      end
      wb_ack_o <= go_resp & ~cur_err;
      wb_err_o <= go_resp &  cur_err;
      wb_dat_o <= (go_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    end
  end

  // The RAM array has no reset. The write is gated by rst so that a
  // zero-wait request seen while reset is held cannot commit.
  always_ff @(posedge clk) begin
    if (go_resp && cur_we && !cur_err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_ram
//   Three instances share one clock and reset, with wait states 0, 1 and 3.
//   Each transfer pushes its expected response to a scoreboard queue. The
//   response is popped and compared when the slave terminates the cycle.
// ---------------------------------------------------------------------------
module tb_wb_slave_ram;

  logic        clk;
  logic        rst;
  logic [31:0] bus_adr  [3];
  logic [31:0] bus_wdat [3];
  logic [31:0] bus_rdat [3];
  logic        bus_we   [3];
  logic [3:0]  bus_sel  [3];
  logic        bus_stb  [3];
  logic        bus_cyc  [3];
  logic        bus_ack  [3];
  logic        bus_err  [3];

  int wc [3] = '{0, 1, 3};

  int checks = 0;
  int passed = 0;

`ifdef WB_RAM_ERR_EN
  localparam logic [31:0] OOR_DAT = 32'h0000_0000;
  localparam bit          OOR_ERR = 1'b1;
`else
  localparam logic [31:0] OOR_DAT = 32'h1234_5678;
  localparam bit          OOR_ERR = 1'b0;
`endif

  wb_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk(clk), .rst(rst),
    .wb_adr_i(bus_adr[0]), .wb_dat_i(bus_wdat[0]), .wb_dat_o(bus_rdat[0]),
    .wb_we_i(bus_we[0]), .wb_sel_i(bus_sel[0]), .wb_stb_i(bus_stb[0]),
    .wb_cyc_i(bus_cyc[0]), .wb_ack_o(bus_ack[0]), .wb_err_o(bus_err[0]));

  wb_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
    .clk(clk), .rst(rst),
    .wb_adr_i(bus_adr[1]), .wb_dat_i(bus_wdat[1]), .wb_dat_o(bus_rdat[1]),
    .wb_we_i(bus_we[1]), .wb_sel_i(bus_sel[1]), .wb_stb_i(bus_stb[1]),
    .wb_cyc_i(bus_cyc[1]), .wb_ack_o(bus_ack[1]), .wb_err_o(bus_err[1]));

  wb_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
    .clk(clk), .rst(rst),
    .wb_adr_i(bus_adr[2]), .wb_dat_i(bus_wdat[2]), .wb_dat_o(bus_rdat[2]),
    .wb_we_i(bus_we[2]), .wb_sel_i(bus_sel[2]), .wb_stb_i(bus_stb[2]),
    .wb_cyc_i(bus_cyc[2]), .wb_ack_o(bus_ack[2]), .wb_err_o(bus_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          k;
    bit          we;
    logic [31:0] dat;
    bit          err;
    int          lat;
  } exp_t;

  vec_t vecs [$];
  exp_t sb   [$];

  // Single comparison point. Every check in the bench steps these counters.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Pop the expected response and compare it with what the slave returned.
  // The following cycle must have no response and cleared read data.
  task automatic checkOutput(input int k, input int lat, input logic ack,
                             input logic err, input logic [31:0] dat);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check($sformatf("latency[w%0d]", wc[k]), 32'(lat), 32'(e.lat));
    check($sformatf("resp_ack_err[w%0d]", wc[k]), {30'd0, ack, err}, {30'd0, ~e.err, e.err});
    if (!e.we) check($sformatf("rdata[w%0d]", wc[k]), dat, e.dat);
    @(posedge clk); #1;
    check($sformatf("single_pulse[w%0d]", wc[k]), {31'd0, bus_ack[k] | bus_err[k]}, 32'd0);
    if (!e.we) check($sformatf("rdata_clear[w%0d]", wc[k]), bus_rdat[k], 32'd0);
  endtask

  // Drive one classic cycle and wait, within a bounded number of cycles, for
  // its termination. The master drops stb/cyc as soon as it sees the response.
  task automatic applyStimulus(input int k, input bit we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input logic [31:0] exp_dat, input bit exp_err);
    int          lat;
    logic        got_ack, got_err;
    logic [31:0] got_dat;
    @(negedge clk);
    bus_adr[k]  = adr;
    bus_wdat[k] = dat;
    bus_sel[k]  = sel;
    bus_we[k]   = we;
    bus_cyc[k]  = 1'b1;
    bus_stb[k]  = 1'b1;
    sb.push_back('{k: k, we: we, dat: exp_dat, err: exp_err, lat: wc[k] + 1});
    lat = -1;
    got_ack = 1'b0; got_err = 1'b0; got_dat = 32'd0;
    for (int c = 1; c <= wc[k] + 6; c++) begin
      @(posedge clk); #1;
      if (bus_ack[k] || bus_err[k]) begin
        lat = c;
        got_ack = bus_ack[k];
        got_err = bus_err[k];
        got_dat = bus_rdat[k];
        break;
      end
    end
    bus_cyc[k] = 1'b0;
    bus_stb[k] = 1'b0;
    bus_we[k]  = 1'b0;
    checkOutput(k, lat, got_ack, got_err, got_dat);
  endtask

  // Count responses on one instance over a fixed number of cycles.
  task automatic countResponses(input int k, input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus_ack[k] || bus_err[k]) seen++;
    end
  endtask

  initial begin
    int seen;

    for (int k = 0; k < 3; k++) begin
      bus_adr[k] = '0; bus_wdat[k] = '0; bus_sel[k] = '0;
      bus_we[k] = 1'b0; bus_stb[k] = 1'b0; bus_cyc[k] = 1'b0;
    end

    vecs.push_back('{1, 1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h10,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h20,   32'h1122_3344, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b1, 32'h20,   32'hAABB_CCDD, 4'h5, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h20,   32'h0,         4'h1, 32'h11BB_33DD, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h20,   32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h20,   32'h0,         4'hF, 32'h11BB_33DD, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h13,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0,    32'h1234_5678, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h1000, 32'h0,         4'hF, OOR_DAT,       OOR_ERR});
    vecs.push_back('{0, 1'b1, 32'h0,    32'hA0A0_A0A0, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h4,    32'h0B0B_0B0B, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,         4'hF, 32'hA0A0_A0A0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h4,    32'h0,         4'hF, 32'h0B0B_0B0B, 1'b0});
    vecs.push_back('{2, 1'b1, 32'h40,   32'h7777_7777, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b1, 32'h44,   32'h1212_1212, 4'hF, 32'h0,         1'b0});

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ack[w%0d]", wc[k]), {31'd0, bus_ack[k]}, 32'd0);
      check($sformatf("reset_err[w%0d]", wc[k]), {31'd0, bus_err[k]}, 32'd0);
      check($sformatf("reset_dat[w%0d]", wc[k]), bus_rdat[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].k, vecs[i].we, vecs[i].adr, vecs[i].dat,
                    vecs[i].sel, vecs[i].exp_dat, vecs[i].exp_err);

    // Abort: cyc drops while the three-wait instance is still waiting.
    @(negedge clk);
    bus_adr[2] = 32'h40; bus_wdat[2] = 32'h0000_0055; bus_sel[2] = 4'hF;
    bus_we[2] = 1'b1; bus_cyc[2] = 1'b1; bus_stb[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_cyc[2] = 1'b0; bus_stb[2] = 1'b0; bus_we[2] = 1'b0;
    countResponses(2, 6, seen);
    check("abort_no_ack", 32'(seen), 32'd0);
    applyStimulus(2, 1'b0, 32'h40, 32'h0, 4'hF, 32'h7777_7777, 1'b0);

    // Reset pulse during the wait phase of a write.
    @(negedge clk);
    bus_adr[2] = 32'h44; bus_wdat[2] = 32'h9999_9999; bus_sel[2] = 4'hF;
    bus_we[2] = 1'b1; bus_cyc[2] = 1'b1; bus_stb[2] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'd0, bus_ack[2]}, 32'd0);
    check("midrst_err", {31'd0, bus_err[2]}, 32'd0);
    check("midrst_dat", bus_rdat[2], 32'd0);
    bus_cyc[2] = 1'b0; bus_stb[2] = 1'b0; bus_we[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    countResponses(2, 6, seen);
    check("midrst_no_ack", 32'(seen), 32'd0);
    applyStimulus(2, 1'b0, 32'h44, 32'h0, 4'hF, 32'h1212_1212, 1'b0);
    applyStimulus(2, 1'b1, 32'h44, 32'h9999_9999, 4'hF, 32'h0, 1'b0);
    applyStimulus(2, 1'b0, 32'h44, 32'h0, 4'hF, 32'h9999_9999, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_ram.md
Name: wb_slave_ram

Overview:
- Wishbone B3 classic-cycle slave: the responder end of the CPU's instruction and data Wishbone master ports.
- Backs a word-organised RAM with byte-lane writes and a programmable number of wait states.
- Sits on the SoC bus behind the CPU core or an arbiter; provides instruction/data memory for simulation and FPGA builds.
- Hand-shaking is a registered FSM; wb_ack_o/wb_err_o are single-cycle pulses.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra wait states inserted between request capture and ack (0..15).
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be word aligned.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wb_adr_i  input  32  byte address
- wb_dat_i  input  32  write data
- wb_dat_o  output  32  read data, valid only while wb_ack_o=1
- wb_we_i  input  1  1=write, 0=read
- wb_sel_i  input  4  byte-lane enables; bit i covers data bits [8i+7:8i]
- wb_stb_i  input  1  strobe
- wb_cyc_i  input  1  bus cycle valid
- wb_ack_o  output  1  normal termination, one-cycle pulse
- wb_err_o  output  1  error termination, one-cycle pulse (0 unless WB_RAM_ERR_EN)

Behaviour:
- Reset: async on rst=1; state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wait counter=0. RAM contents not reset.
- Reset mid-transaction: aborts immediately; no write, no ack.
- Address decode:
  - offset = wb_adr_i - BASE_ADDR; word index = offset[ADDR_W+1:2].
  - adr[1:0] are ignored.
  - Offsets beyond the window wrap (upper bits ignored) unless WB_RAM_ERR_EN.
- FSM IDLE:
  - On wb_cyc_i & wb_stb_i, latch adr/dat/sel/we and load counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT.
- FSM WAIT:
  - Decrement the counter each cycle; on the cycle it is 1, go to RESP.
  - If wb_cyc_i drops, go to IDLE; no write, no ack.
- FSM RESP: for one cycle, drive wb_ack_o=1 (or wb_err_o), then return to IDLE.
- Latency: ack is high exactly WAIT_CYCLES+1 cycles after the first cycle in which cyc&stb are sampled high.
  - WAIT_CYCLES=0 gives ack in the cycle after the request.
  - Throughput: one transfer per WAIT_CYCLES+2 cycles.
- Write: on the edge that enters RESP, RAM[idx] lanes with latched sel=1 take the latched data; other lanes are unchanged.
  - sel=4'b0000 write: acks normally and modifies nothing.
- Read: wb_dat_o is registered with RAM[idx] on the edge entering RESP, so it is valid with the ack.
  - wb_dat_o returns to 0 the following cycle.
  - All 4 lanes are returned regardless of sel.
- Master holding stb across ack: RESP→IDLE, and IDLE resamples on the next cycle as a new transfer. Masters must drop stb after ack per classic protocol.
- wb_cyc_i low in RESP: the response is still issued; the write has already committed.
- wb_ack_o and wb_err_o are never high together.

Optional Feature:
- WB_RAM_ERR_EN defined:
  - A request with offset ≥ 4·2^ADDR_W, or below BASE_ADDR (unsigned wrap), terminates with wb_err_o=1 instead of ack.
  - Timing is the same as ack; no RAM write; wb_dat_o=0.
- Not defined: wb_err_o is tied 0 and addresses wrap modulo window size.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 → ack pulse 2 cycles after stb on each transfer; read returns 0xDEADBEEF.
- Write 0x11223344 sel=4'hF to 0x20, then 0xAABBCCDD sel=4'b0101 to 0x20, then read → 0x11BB33DD.
- WAIT_CYCLES=3: drop wb_cyc_i 2 cycles into a write of 0x55 to 0x40 → no ack; subsequent read of 0x40 returns the prior value.
- Assert rst for 1 cycle during the WAIT state of a write → outputs 0, no ack, RAM word unchanged, next transfer completes normally.
- ADDR_W=10, WB_RAM_ERR_EN: read 0x1000 → wb_err_o pulse, wb_ack_o=0, dat_o=0. Without the macro, the same read returns RAM[0] with ack.
- WAIT_CYCLES=0: back-to-back reads at 0x0 and 0x4 with stb dropped for one cycle between → ack each 1 cycle after request, correct data, ack never high for 2 consecutive cycles.
